// File: rtl/add_1_checker.sv
// Checks a full-adder-under-test over NUM_VECTORS valid vectors.
// Reports pass/fail, error count and the first failing vector.
module add_1_checker #(
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic             in_0,
  input  logic             in_1,
  input  logic             cin,
  input  logic             out,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [4:0]       first_err_vec
);

  // state  | meaning
  // IDLE   | waiting for the first start after reset
  // RUN    | checking one vector per vld cycle
  // DONE   | run complete, results held until the next start
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  state_t state, state_next;

  logic exp_out;
  logic exp_cout;
  logic mismatch;
  logic check_en;
  logic launch;

  assign exp_out  = in_0 ^ in_1 ^ cin;
  assign exp_cout = (in_0 & in_1) | (cin & (in_0 ^ in_1));
  assign mismatch = (out != exp_out) || (cout != exp_cout);
  assign check_en = (state == S_RUN) && vld;
  // start is ignored while a run is in progress
  assign launch   = start && (state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (vld && (vec_cnt == LAST_IDX)) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decode flops only, so nothing combinational reaches them from inputs.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (launch) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (check_en) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mismatch) begin
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        // err_cnt never returns to zero within a run, so this latches only the first error
        if (err_cnt == '0) begin
          first_err_idx <= vec_cnt;
          first_err_vec <= {in_0, in_1, cin, out, cout};
        end
      end
    end
  end

endmodule

// File: tb/tb_add_1_checker.sv
// Directed, table-driven bench for add_1_checker: default instance plus a
// CNT_W=2 / NUM_VECTORS=3 instance for the saturation corner.
module tb_add_1_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, vld, in_0, in_1, cin, sum_in, cout_in;
  logic       busy, done, pass;
  logic [7:0] vec_cnt, err_cnt, first_err_idx;
  logic [4:0] first_err_vec;

  logic       s_start, s_vld, s_in_0, s_in_1, s_cin, s_sum, s_cout;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_vec_cnt, s_err_cnt, s_first_err_idx;
  logic [4:0] s_first_err_vec;

  add_1_checker #(.NUM_VECTORS(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vld(vld),
    .in_0(in_0), .in_1(in_1), .cin(cin), .out(sum_in), .cout(cout_in),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_vec(first_err_vec)
  );

  add_1_checker #(.NUM_VECTORS(3), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .vld(s_vld),
    .in_0(s_in_0), .in_1(s_in_1), .cin(s_cin), .out(s_sum), .cout(s_cout),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt),
    .first_err_idx(s_first_err_idx), .first_err_vec(s_first_err_vec)
  );

  typedef struct {
    bit         toggle;
    int         bad_a;
    logic [4:0] vec_a;
    int         bad_b;
    logic [4:0] vec_b;
    int         exp_edge;
    bit         exp_pass;
    int         exp_err;
    int         exp_idx;
    logic [4:0] exp_vec;
  } scen_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] vecs [16];
  scen_t scen [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Correct adder response for operand pattern i[2:0] = {in_0,in_1,cin}.
  function automatic logic [4:0] good_vec(input int i);
    logic a, b, c;
    a = i[2];
    b = i[1];
    c = i[0];
    return {a, b, c, a ^ b ^ c, (a & b) | (c & (a ^ b))};
  endfunction

  task automatic fill_good();
    for (int k = 0; k < 16; k++) vecs[k] = good_vec(k);
  endtask

  // start with a wrong vector on vld in the same cycle: it must not be checked.
  task automatic do_run(input bit toggle, output int done_edge);
    int edges;
    edges = 0;
    done_edge = -1;
    start = 1'b1;
    vld = 1'b1;
    {in_0, in_1, cin, sum_in, cout_in} = 5'b11000;
    tick();
    start = 1'b0;
    vld = 1'b0;
    check("busy_after_start", busy, 1);
    check("vec_cnt_after_start", vec_cnt, 0);
    check("err_cnt_after_start", err_cnt, 0);
    for (int k = 0; k < 16; k++) begin
      {in_0, in_1, cin, sum_in, cout_in} = vecs[k];
      vld = 1'b1;
      tick();
      edges++;
      if (done && done_edge < 0) done_edge = edges;
      vld = 1'b0;
      if (toggle && k < 15) begin
        start = 1'b1;
        {in_0, in_1, cin, sum_in, cout_in} = 5'b11111;
        tick();
        edges++;
        if (done && done_edge < 0) done_edge = edges;
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int de;
    scen[0] = '{1'b0, -1, 5'b00000, -1, 5'b00000, 16, 1'b1, 0, 0, 5'b00000};
    scen[1] = '{1'b0,  5, 5'b11000, -1, 5'b00000, 16, 1'b0, 1, 5, 5'b11000};
    scen[2] = '{1'b0,  2, 5'b00010,  9, 5'b10110, 16, 1'b0, 2, 2, 5'b00010};
    scen[3] = '{1'b1, -1, 5'b00000, -1, 5'b00000, 31, 1'b1, 0, 0, 5'b00000};

    rst = 1'b1;
    {start, vld, in_0, in_1, cin, sum_in, cout_in} = '0;
    {s_start, s_vld, s_in_0, s_in_1, s_cin, s_sum, s_cout} = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_idx", first_err_idx, 0);
    check("rst_first_vec", first_err_vec, 0);
    check("rst_small_busy", s_busy, 0);
    check("rst_small_err", s_err_cnt, 0);
    rst = 1'b0;

    // vld outside RUN after reset is ignored
    vld = 1'b1;
    {in_0, in_1, cin, sum_in, cout_in} = 5'b11000;
    tick();
    vld = 1'b0;
    check("idle_vld_vec_cnt", vec_cnt, 0);
    check("idle_vld_busy", busy, 0);

    // Runs chain back to back: each later start is issued from DONE.
    for (int s = 0; s < 4; s++) begin
      fill_good();
      if (scen[s].bad_a >= 0) vecs[scen[s].bad_a] = scen[s].vec_a;
      if (scen[s].bad_b >= 0) vecs[scen[s].bad_b] = scen[s].vec_b;
      do_run(scen[s].toggle, de);
      check($sformatf("s%0d_done_edge", s), de, scen[s].exp_edge);
      check($sformatf("s%0d_done", s), done, 1);
      check($sformatf("s%0d_busy", s), busy, 0);
      check($sformatf("s%0d_pass", s), pass, scen[s].exp_pass);
      check($sformatf("s%0d_vec_cnt", s), vec_cnt, 16);
      check($sformatf("s%0d_err_cnt", s), err_cnt, scen[s].exp_err);
      check($sformatf("s%0d_first_idx", s), first_err_idx, scen[s].exp_idx);
      check($sformatf("s%0d_first_vec", s), first_err_vec, scen[s].exp_vec);
      vld = 1'b1;
      {in_0, in_1, cin, sum_in, cout_in} = 5'b00011;
      tick();
      vld = 1'b0;
      check($sformatf("s%0d_hold_vec_cnt", s), vec_cnt, 16);
      check($sformatf("s%0d_hold_err_cnt", s), err_cnt, scen[s].exp_err);
      check($sformatf("s%0d_hold_done", s), done, 1);
    end

    // Reset mid-run after 7 vectors, with start and vld also high.
    fill_good();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      {in_0, in_1, cin, sum_in, cout_in} = (k == 3) ? 5'b00010 : vecs[k];
      vld = 1'b1;
      tick();
    end
    check("mid_vec_cnt", vec_cnt, 7);
    check("mid_err_cnt", err_cnt, 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_vec_cnt", vec_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_first_idx", first_err_idx, 0);
    check("midrst_first_vec", first_err_vec, 0);
    tick();
    tick();
    vld = 1'b0;
    check("post_rst_no_run_busy", busy, 0);
    check("post_rst_no_run_vec_cnt", vec_cnt, 0);
    do_run(1'b0, de);
    check("fresh_done_edge", de, 16);
    check("fresh_pass", pass, 1);
    check("fresh_vec_cnt", vec_cnt, 16);

    // Small instance: every vector wrong, err_cnt reaches all-ones.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("small_busy", s_busy, 1);
    s_vld = 1'b1;
    {s_in_0, s_in_1, s_cin, s_sum, s_cout} = 5'b00010;
    tick();
    tick();
    check("small_not_done_2", s_done, 0);
    tick();
    check("small_done_3", s_done, 1);
    check("small_pass", s_pass, 0);
    check("small_vec_cnt", s_vec_cnt, 3);
    check("small_err_cnt", s_err_cnt, 3);
    check("small_first_idx", s_first_err_idx, 0);
    check("small_first_vec", s_first_err_vec, 5'b00010);
    tick();
    check("small_hold_err", s_err_cnt, 3);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_vld = 1'b0;
    check("small_restart_err", s_err_cnt, 0);
    check("small_restart_vec", s_vec_cnt, 0);
    check("small_restart_busy", s_busy, 1);
    check("small_restart_done", s_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_1_checker.md
ADD_1_CHECKER -- requirements
Module: add_1_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 16, meaning the number of valid vectors checked per run (legal range 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of all counters and index outputs.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a pulse that begins a run.
REQ-006 The block SHALL have port vld, input, 1, marking the current vector as valid for checking.
REQ-007 The block SHALL have ports in_0, in_1 and cin, input, 1 each, the operand and carry-in applied to the full adder under test.
REQ-008 The block SHALL have ports out and cout, input, 1 each, the sum and carry-out returned by the adder under test.
REQ-009 The block SHALL have port busy, output, 1, asserted while in RUN.
REQ-010 The block SHALL have port done, output, 1, asserted while in DONE.
REQ-011 The block SHALL have port pass, output, 1, valid only when done=1: 1 when no mismatch occurred in the run.
REQ-012 The block SHALL have port vec_cnt, output, CNT_W, the number of vectors checked in the current or last run.
REQ-013 The block SHALL have port err_cnt, output, CNT_W, the number of mismatching vectors, saturating at all-ones.
REQ-014 The block SHALL have port first_err_idx, output, CNT_W, the vec_cnt value of the first mismatching vector.
REQ-015 The block SHALL have port first_err_vec, output, 5, the first failing vector packed as {in_0,in_1,cin,out,cout}.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE with start=1, the block SHALL enter RUN on the next edge and clear vec_cnt, err_cnt, first_err_idx and first_err_vec to 0 on that same edge.
REQ-018 In RUN, a vector SHALL be checked on every edge where vld=1; cycles with vld=0 SHALL change nothing.
REQ-019 Expected results SHALL be computed as exp_out = in_0^in_1^cin and exp_cout = (in_0&in_1)|(cin&(in_0^in_1)).
REQ-020 A mismatch SHALL be flagged when out!=exp_out or cout!=exp_cout.
REQ-021 Each checked vector SHALL increment vec_cnt by 1, registered so it is visible one cycle after the vld edge.
REQ-022 On a mismatch, err_cnt SHALL increment by 1 and SHALL hold at 2^CNT_W-1 rather than wrap.
REQ-023 On the first mismatch of a run only, first_err_idx SHALL be loaded with the pre-increment vec_cnt, and first_err_vec SHALL be loaded with the sampled inputs.
REQ-024 When the vector being checked is the NUM_VECTORS-th (vec_cnt==NUM_VECTORS-1 with vld=1), the block SHALL check it and then enter DONE on the same edge, so done rises one cycle after the final vld.
REQ-025 In DONE, all outputs SHALL hold, with pass = (err_cnt==0).
REQ-026 In DONE, start=1 SHALL enter RUN with all counters cleared, exactly as from IDLE.
REQ-027 In RUN, start SHALL be ignored; vld outside RUN SHALL be ignored.
REQ-028 When start and vld are both 1 in IDLE or DONE, that vld SHALL NOT be checked; checking begins the following cycle.
REQ-029 busy, done and pass SHALL be registered outputs with no combinational input-to-output path.
REQ-030 With NUM_VECTORS=1, a single vld in RUN SHALL complete the run.

Reset
REQ-031 When rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, pass, vec_cnt, err_cnt, first_err_idx and first_err_vec SHALL all be 0.
REQ-032 rst SHALL take priority over start and vld in every state, including mid-run.
REQ-033 After rst deasserts, a new start SHALL be required to begin a run.

Verification
REQ-034 Bench SHALL cover: reset, then start, then 16 correct vectors with vld held high -> done=1 at cycle 17 after start edge, pass=1, vec_cnt=16, err_cnt=0.
REQ-035 Bench SHALL cover: run where vector index 5 drives in_0=1,in_1=1,cin=0,out=0,cout=0 (wrong carry) -> pass=0, err_cnt=1, first_err_idx=5, first_err_vec=5'b11000.
REQ-036 Bench SHALL cover: mismatches at indices 2 and 9 -> err_cnt=2, first_err_idx=2 (not 9).
REQ-037 Bench SHALL cover: vld toggled 1/0 alternately -> done only after 16 vld cycles (~32 cycles), vec_cnt=16.
REQ-038 Bench SHALL cover: rst pulsed after 7 vectors -> next cycle busy=0, vec_cnt=0; later start gives a fresh run with pass=1.
REQ-039 Bench SHALL cover: CNT_W=2, NUM_VECTORS=3, all vectors wrong -> err_cnt=3 (saturated), done after 3 vectors; then start in DONE clears err_cnt to 0.
